// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: arbitrated, queued BTB/BHT write port with an invalidate walk after reset/flush
module btb_update_ctrl #(
   parameter int WORD_SIZE  = 16,
   parameter int IDX_BITS   = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          br_req_valid,
   input  logic [WORD_SIZE-1:0]          br_pc,
   input  logic [WORD_SIZE-1:0]          br_target,
   input  logic                          br_taken,
   output logic                          br_ready,
   input  logic                          jmp_req_valid,
   input  logic [WORD_SIZE-1:0]          jmp_pc,
   input  logic [WORD_SIZE-1:0]          jmp_target,
   output logic                          jmp_ready,
   input  logic                          flush_req,
   output logic                          btb_we,
   output logic [IDX_BITS-1:0]           btb_idx,
   output logic [WORD_SIZE-IDX_BITS-1:0] btb_tag,
   output logic [WORD_SIZE-1:0]          btb_target,
   output logic                          btb_entry_valid,
   output logic                          bht_we,
   output logic                          bht_taken,
   output logic                          bht_init,
   output logic                          busy
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int TW = WORD_SIZE - IDX_BITS;

   typedef enum logic {CLEAR, RUN} state_t;

   state_t               state, state_d;
   logic [IDX_BITS-1:0]  clr_cnt, clr_d;
   logic [WORD_SIZE-1:0] q_pc  [FIFO_DEPTH];
   logic [WORD_SIZE-1:0] q_tgt [FIFO_DEPTH];
   logic                 q_br  [FIFO_DEPTH];
   logic                 q_tk  [FIFO_DEPTH];
   logic [PW-1:0]        head, tail;
   logic [CW-1:0]        count, free;
   logic                 run, br_acc, jmp_acc, deq;
   logic [WORD_SIZE-1:0] head_pc;
   logic                 we_d, ev_d, bht_we_d, tk_d, init_d, busy_d;
   logic [IDX_BITS-1:0]  idx_d;
   logic [TW-1:0]        tag_d;
   logic [WORD_SIZE-1:0] tgt_d;

   // Readiness ignores the same-cycle dequeue; the branch reserves its slot before the jump.
   always_comb begin
      run       = (state == RUN) && !flush_req;
      free      = CW'(FIFO_DEPTH) - count;
      br_ready  = run && (free >= CW'(1));
      jmp_ready = run && (free >= (br_req_valid ? CW'(2) : CW'(1)));
      br_acc    = br_req_valid && br_ready;
      jmp_acc   = jmp_req_valid && jmp_ready;
      deq       = run && (count != '0);
      head_pc   = q_pc[head];
   end

   // Next state and next values of the registered write port.
   always_comb begin
      state_d  = state;
      clr_d    = clr_cnt;
      we_d     = 1'b0;
      bht_we_d = 1'b0;
      init_d   = 1'b0;
      busy_d   = 1'b0;
      idx_d    = btb_idx;
      tag_d    = btb_tag;
      tgt_d    = btb_target;
      ev_d     = btb_entry_valid;
      tk_d     = bht_taken;
      if (flush_req) begin
         state_d = CLEAR;
         clr_d   = '0;
         busy_d  = 1'b1;
      end else if (state == CLEAR) begin
         state_d = (clr_cnt == '1) ? RUN : CLEAR;
         clr_d   = clr_cnt + 1'b1;
         we_d    = 1'b1;
         idx_d   = clr_cnt;
         tag_d   = '0;
         tgt_d   = '0;
         ev_d    = 1'b0;
         init_d  = 1'b1;
         busy_d  = 1'b1;
      end else if (deq) begin
         we_d     = 1'b1;
         idx_d    = head_pc[IDX_BITS-1:0];
         tag_d    = head_pc[WORD_SIZE-1:IDX_BITS];
         tgt_d    = q_tgt[head];
         ev_d     = 1'b1;
         bht_we_d = q_br[head];
         tk_d     = q_tk[head];
      end
   end

   // State, walk counter, queue pointers and output registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state           <= CLEAR;
         clr_cnt         <= '0;
         head            <= '0;
         tail            <= '0;
         count           <= '0;
         btb_we          <= 1'b0;
         btb_idx         <= '0;
         btb_tag         <= '0;
         btb_target      <= '0;
         btb_entry_valid <= 1'b0;
         bht_we          <= 1'b0;
         bht_taken       <= 1'b0;
         bht_init        <= 1'b0;
         busy            <= 1'b1;
      end else begin
         state           <= state_d;
         clr_cnt         <= clr_d;
         head            <= flush_req ? '0 : head + PW'(deq);
         tail            <= flush_req ? '0 : tail + PW'(br_acc) + PW'(jmp_acc);
         count           <= flush_req ? '0 : count + CW'(br_acc) + CW'(jmp_acc) - CW'(deq);
         btb_we          <= we_d;
         btb_idx         <= idx_d;
         btb_tag         <= tag_d;
         btb_target      <= tgt_d;
         btb_entry_valid <= ev_d;
         bht_we          <= bht_we_d;
         bht_taken       <= tk_d;
         bht_init        <= init_d;
         busy            <= busy_d;
      end
   end

   // Queue storage; the jump lands behind the branch when both are accepted together.
   always_ff @(posedge clk) begin
      if (br_acc) begin
         q_pc[tail]  <= br_pc;
         q_tgt[tail] <= br_target;
         q_br[tail]  <= 1'b1;
         q_tk[tail]  <= br_taken;
      end
      if (jmp_acc) begin
         q_pc[tail + PW'(br_acc)]  <= jmp_pc;
         q_tgt[tail + PW'(br_acc)] <= jmp_target;
         q_br[tail + PW'(br_acc)]  <= 1'b0;
         q_tk[tail + PW'(br_acc)]  <= 1'b0;
      end
   end
endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb_btb_update_ctrl: directed vectors for the BTB update controller
module tb_btb_update_ctrl;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        br_req_valid, br_taken, br_ready;
   logic [15:0] br_pc, br_target;
   logic        jmp_req_valid, jmp_ready;
   logic [15:0] jmp_pc, jmp_target;
   logic        flush_req;
   logic        btb_we, btb_entry_valid, bht_we, bht_taken, bht_init, busy;
   logic [7:0]  btb_idx, btb_tag;
   logic [15:0] btb_target;
   int          n_cmp = 0;
   int          n_bad = 0;

   btb_update_ctrl dut (
      .clk(clk), .reset_n(reset_n),
      .br_req_valid(br_req_valid), .br_pc(br_pc), .br_target(br_target),
      .br_taken(br_taken), .br_ready(br_ready),
      .jmp_req_valid(jmp_req_valid), .jmp_pc(jmp_pc), .jmp_target(jmp_target),
      .jmp_ready(jmp_ready), .flush_req(flush_req),
      .btb_we(btb_we), .btb_idx(btb_idx), .btb_tag(btb_tag), .btb_target(btb_target),
      .btb_entry_valid(btb_entry_valid), .bht_we(bht_we), .bht_taken(bht_taken),
      .bht_init(bht_init), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic walk();
      for (int i = 0; i < 256; i++) begin
         step();
         chk("walk_we", btb_we, 1);
         chk("walk_idx", btb_idx, i);
         chk("walk_ev", btb_entry_valid, 0);
         chk("walk_init", bht_init, 1);
         chk("walk_busy", busy, 1);
         if (i < 255) chk("walk_br_ready", br_ready, 0);
      end
      step();
      chk("walk_end_busy", busy, 0);
      chk("walk_end_we", btb_we, 0);
      chk("walk_end_init", bht_init, 0);
   endtask

   task automatic put_br(input logic v, input logic [15:0] pc, input logic [15:0] t, input logic tk);
      br_req_valid = v;
      br_pc = pc;
      br_target = t;
      br_taken = tk;
   endtask

   task automatic put_jmp(input logic v, input logic [15:0] pc, input logic [15:0] t);
      jmp_req_valid = v;
      jmp_pc = pc;
      jmp_target = t;
   endtask

   logic [7:0] exp_idx [5] = '{8'h00, 8'h10, 8'h01, 8'h11, 8'h02};
   logic       exp_bw  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   logic       exp_jr  [3] = '{1'b1, 1'b1, 1'b0};

   initial begin
      reset_n = 1'b0;
      flush_req = 1'b0;
      put_br(0, 0, 0, 0);
      put_jmp(0, 0, 0);
      step();
      step();
      chk("rst_we", btb_we, 0);
      chk("rst_busy", busy, 1);
      chk("rst_idx", btb_idx, 0);
      chk("rst_init", bht_init, 0);
      chk("rst_br_ready", br_ready, 0);
      reset_n = 1'b1;
      walk();

      put_br(1, 16'h1234, 16'h1250, 1);
      #1 chk("single_br_ready", br_ready, 1);
      step();
      put_br(0, 0, 0, 0);
      chk("single_gap_we", btb_we, 0);
      step();
      chk("single_we", btb_we, 1);
      chk("single_idx", btb_idx, 8'h34);
      chk("single_tag", btb_tag, 8'h12);
      chk("single_tgt", btb_target, 16'h1250);
      chk("single_ev", btb_entry_valid, 1);
      chk("single_bht_we", bht_we, 1);
      chk("single_taken", bht_taken, 1);
      chk("single_init", bht_init, 0);
      step();
      chk("single_after_we", btb_we, 0);
      chk("single_after_bht_we", bht_we, 0);
      chk("single_hold_idx", btb_idx, 8'h34);

      put_br(1, 16'h2010, 16'h2020, 0);
      put_jmp(1, 16'h3011, 16'h3100);
      #1 chk("pair_br_ready", br_ready, 1);
      chk("pair_jmp_ready", jmp_ready, 1);
      step();
      put_br(0, 0, 0, 0);
      put_jmp(0, 0, 0);
      step();
      chk("pair_br_we", btb_we, 1);
      chk("pair_br_idx", btb_idx, 8'h10);
      chk("pair_br_tag", btb_tag, 8'h20);
      chk("pair_br_bht_we", bht_we, 1);
      chk("pair_br_taken", bht_taken, 0);
      step();
      chk("pair_jmp_we", btb_we, 1);
      chk("pair_jmp_idx", btb_idx, 8'h11);
      chk("pair_jmp_tag", btb_tag, 8'h30);
      chk("pair_jmp_tgt", btb_target, 16'h3100);
      chk("pair_jmp_bht_we", bht_we, 0);
      step();
      chk("pair_idle_we", btb_we, 0);

      for (int c = 0; c < 3; c++) begin
         put_br(1, 16'h4100 + 16'(c), 16'h5100 + 16'(c), 1);
         put_jmp(1, 16'h6110 + 16'(c), 16'h7110 + 16'(c));
         #1 chk("burst_br_ready", br_ready, 1);
         chk("burst_jmp_ready", jmp_ready, exp_jr[c]);
         if (c > 0) chk("burst_out_we", btb_we, c > 1);
         if (c == 2) chk("burst_out_idx", btb_idx, exp_idx[0]);
         step();
      end
      put_br(0, 0, 0, 0);
      put_jmp(0, 0, 0);
      for (int k = 1; k < 5; k++) begin
         chk("burst_drain_we", btb_we, 1);
         chk("burst_drain_idx", btb_idx, exp_idx[k]);
         chk("burst_drain_bht_we", bht_we, exp_bw[k]);
         step();
      end
      chk("burst_empty_we", btb_we, 0);

      for (int c = 0; c < 2; c++) begin
         put_br(1, 16'h8800 + 16'(c), 16'h9900, 1);
         put_jmp(1, 16'h8A00 + 16'(c), 16'h9A00);
         step();
      end
      chk("fl_pre_idx", btb_idx, 8'h00);
      chk("fl_pre_we", btb_we, 1);
      flush_req = 1'b1;
      #1 chk("fl_br_ready", br_ready, 0);
      chk("fl_jmp_ready", jmp_ready, 0);
      step();
      flush_req = 1'b0;
      put_br(0, 0, 0, 0);
      put_jmp(0, 0, 0);
      chk("fl_we", btb_we, 0);
      chk("fl_busy", busy, 1);
      walk();
      step();
      chk("fl_nothing_left", btb_we, 0);

      flush_req = 1'b1;
      step();
      flush_req = 1'b0;
      for (int i = 0; i < 100; i++) step();
      chk("mid_idx99", btb_idx, 99);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      chk("mid_rst_we", btb_we, 0);
      chk("mid_rst_busy", busy, 1);
      chk("mid_rst_idx", btb_idx, 0);
      chk("mid_rst_init", bht_init, 0);
      walk();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
